// File: rtl/seven_seg_scan.sv
// Purpose: time-multiplexed 4-digit common-anode 7-segment driver with a double-buffered value, anti-ghost blanking and leading-zero suppression.
// Latency: outputs are registered one cycle behind the scan state; a captured update appears from digit 0 of the next frame.
// Backpressure: none; upd is accepted every cycle, and the last strobe within a frame wins.
module seven_seg_scan #(
    parameter int PRESCALE_W = 16,
    parameter int GHOST      = 4,
    parameter int LZB        = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        upd,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam logic [PRESCALE_W-1:0] GHOST_CNT = PRESCALE_W'(GHOST);

    logic [PRESCALE_W-1:0] cnt;
    logic [1:0]            idx;
    logic [15:0]           pend_val;
    logic [3:0]            pend_dp;
    logic                  pend_v;
    logic [15:0]           act_val;
    logic [3:0]            act_dp;

    logic       slot_end;
    logic       frame_bnd;
    logic       ghost;
    logic       blank_lz;
    logic [3:0] nib;

    // Hex digit to active-high {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign slot_end  = (cnt == '1);
    assign frame_bnd = slot_end && (idx == 2'd3);

    // Decode the current digit: its nibble, ghost window and leading-zero blanking.
    always_comb begin
        nib      = act_val[{idx, 2'b00} +: 4];
        ghost    = (cnt < GHOST_CNT);
        blank_lz = 1'b0;
        if (LZB != 0) begin
            case (idx)
                2'd1:    blank_lz = (act_val[15:4]  == 12'h000);
                2'd2:    blank_lz = (act_val[15:8]  == 8'h00);
                2'd3:    blank_lz = (act_val[15:12] == 4'h0);
                default: blank_lz = 1'b0;
            endcase
        end
    end

    // Scan counters and the pending/active double buffer; act only moves at frame boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_v     <= 1'b0;
            act_val    <= 16'h0000;
            act_dp     <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            frame_tick <= frame_bnd;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            if (upd) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            if (frame_bnd && upd) begin
                // A strobe landing on the boundary goes straight to the display.
                act_val <= value;
                act_dp  <= dp_in;
                pend_v  <= 1'b0;
            end else if (frame_bnd && pend_v) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                pend_v  <= 1'b0;
            end else if (upd) begin
                pend_v <= 1'b1;
            end
        end
    end

    // Registered display outputs, all active-low.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ghost    ? 4'b1111 : ~(4'b0001 << idx);
            seg <= blank_lz ? 7'h7F   : ~hex7(nib);
            dp  <= blank_lz ? 1'b1    : ~act_dp[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (leading-zero blanking on and off) against a position-based display model.
// Every clock edge compares seg, dp, an and frame_tick of both instances plus the one-anode-low rule.
// Stimulus: directed display scenarios followed by random updates and occasional resets.
module tb_seven_seg_scan;

    localparam int PW    = 3;
    localparam int GH    = 2;
    localparam int SLOT  = 1 << PW;
    localparam int FRAME = 4 * SLOT;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        upd   = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;

    logic [6:0] seg_lz, seg_nz;
    logic       dp_lz, dp_nz;
    logic [3:0] an_lz, an_nz;
    logic       ft_lz, ft_nz;

    seven_seg_scan #(.PRESCALE_W(PW), .GHOST(GH), .LZB(1)) dut_lz (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .upd(upd),
        .seg(seg_lz), .dp(dp_lz), .an(an_lz), .frame_tick(ft_lz)
    );

    seven_seg_scan #(.PRESCALE_W(PW), .GHOST(GH), .LZB(0)) dut_nz (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .upd(upd),
        .seg(seg_nz), .dp(dp_nz), .an(an_nz), .frame_tick(ft_nz)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Display model: pos counts scan cycles since reset; a frame shows the latest update made before it started.
    int          pos   = 0;
    logic [15:0] act_v = 16'h0000;
    logic [3:0]  act_d = 4'h0;
    logic [15:0] lat_v = 16'h0000;
    logic [3:0]  lat_d = 4'h0;

    logic [6:0] e_seg [2];
    logic       e_dp  [2];
    logic [3:0] e_an;
    logic       e_ft;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t pos=%0d: got=%h expected=%h", tag, $time, pos, got, exp);
        end
    endtask

    task automatic step();
        int cnt;
        int dig;
        int nib;
        bit blank;
        @(posedge clk);
        if (reset) begin
            e_an  = 4'b1111;
            e_ft  = 1'b0;
            for (int lz = 0; lz < 2; lz++) begin
                e_seg[lz] = 7'h7F;
                e_dp[lz]  = 1'b1;
            end
            pos   = 0;
            act_v = 16'h0000;
            act_d = 4'h0;
            lat_v = 16'h0000;
            lat_d = 4'h0;
        end else begin
            cnt  = pos % SLOT;
            dig  = (pos / SLOT) % 4;
            e_an = (cnt < GH) ? 4'b1111 : ~(4'(1) << dig);
            e_ft = ((pos % FRAME) == FRAME - 1);
            nib  = (int'(act_v) >> (4 * dig)) % 16;
            for (int lz = 0; lz < 2; lz++) begin
                blank     = (lz == 1) && (dig != 0) && ((int'(act_v) >> (4 * dig)) == 0);
                e_seg[lz] = blank ? 7'h7F : ~HEX[nib];
                e_dp[lz]  = blank ? 1'b1  : ~act_d[dig];
            end
            if (upd) begin
                lat_v = value;
                lat_d = dp_in;
            end
            pos++;
            if ((pos % FRAME) == 0) begin
                act_v = lat_v;
                act_d = lat_d;
            end
        end
        #1;
        chk("an_lz",  32'(an_lz),  32'(e_an));
        chk("seg_lz", 32'(seg_lz), 32'(e_seg[1]));
        chk("dp_lz",  32'(dp_lz),  32'(e_dp[1]));
        chk("ft_lz",  32'(ft_lz),  32'(e_ft));
        chk("an_nz",  32'(an_nz),  32'(e_an));
        chk("seg_nz", 32'(seg_nz), 32'(e_seg[0]));
        chk("dp_nz",  32'(dp_nz),  32'(e_dp[0]));
        chk("ft_nz",  32'(ft_nz),  32'(e_ft));
        chk("one_anode", 32'($countones(~an_lz) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the scan position within the frame equals p (bounded to two frames).
    task automatic goto_pos(input int p);
        for (int i = 0; i < 2 * FRAME && (pos % FRAME) != p; i++) step();
        chk("goto_pos", 32'(pos % FRAME), 32'(p));
    endtask

    task automatic pulse(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        upd   = 1'b1;
        step();
        upd   = 1'b0;
    endtask

    initial begin
        // Reset held two cycles, then an unloaded scan of a blank (zero) value.
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(40);

        // Mixed hex digits with a decimal point on digit 2.
        goto_pos(5);
        pulse(16'h12AF, 4'b0100);
        run(2 * FRAME);

        // Leading zeros, then an all-zero value.
        pulse(16'h0070, 4'b0000);
        run(2 * FRAME);
        pulse(16'h0000, 4'b0000);
        run(2 * FRAME);

        // Two updates inside one frame: only the second is ever shown.
        goto_pos(FRAME / 2);
        pulse(16'h1111, 4'b0001);
        run(1);
        pulse(16'h2222, 4'b0010);
        run(2 * FRAME);

        // Update exactly on the frame-boundary cycle.
        goto_pos(FRAME - 1);
        pulse(16'hBEEF, 4'b1000);
        run(FRAME + 2);

        // Reset in the digit-2 slot with an update still pending.
        goto_pos(2 * SLOT + 3);
        pulse(16'h5A5A, 4'b1111);
        run(2);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(2 * FRAME);

        // Random updates (some with leading zeros) and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in = 4'($urandom);
            upd   = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        upd   = 1'b0;
        reset = 1'b0;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
